auto_sequencer: RTL

- Parametrised auto-play note sequencer; successor to the fixed-length, fixed-tempo auto mode.
- Fetches (note, duration, octave) entries from an external song ROM over a request/valid handshake.
- Times each note in clock ticks and drives the buzzer note code, octave and a one-hot LED.
- Adds pause, tempo scaling, end-of-song stop/loop and song select with wrap; sits between the mode mux and the buzzer/LED drivers.

---
 rtl/auto_sequencer_pkg.sv | 30 +++
 rtl/auto_sequencer_edge_detect.sv | 22 ++
 rtl/auto_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/auto_sequencer_pkg.sv
// Shared definitions for the auto-play sequencer: note codes, FSM states, LED decode.
// The GAP state exists only when AUTO_SEQ_GAP_EN is defined.
package auto_sequencer_pkg;

   localparam logic [3:0] NOTE_REST = 4'h0;
   localparam logic [3:0] NOTE_END  = 4'hF;

   typedef enum logic [2:0] {
      ST_FETCH = 3'd0,
      ST_WAIT  = 3'd1,
      ST_PLAY  = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DONE  = 3'd4
`ifdef AUTO_SEQ_GAP_EN
      ,ST_GAP  = 3'd5
`endif
   } state_e;

   function automatic logic [6:0] note_to_led(input logic [3:0] note);
      logic [6:0] led;
      led = 7'd0;
      if (note >= 4'd1 && note <= 4'd7) begin
         led = 7'd1 << (note - 4'd1);
      end else begin
         led = 7'd0;
      end
      return led;
   endfunction

endpackage

// File: rtl/auto_sequencer_edge_detect.sv
// Rising-edge detector on an already-synchronised level input.
module edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic sig_i,
   output logic rise_o
);

   logic sig_q;

   // previous-sample copy of the input
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig_i;
      end
   end

   assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/auto_sequencer.sv
// Auto-play note sequencer: fetches (note, dur, octave) from a song ROM and times each note.
// Define AUTO_SEQ_GAP_EN to insert GAP_TICKS cycles of silence between notes.
module auto_sequencer
   import auto_sequencer_pkg::*;
#(
   parameter int TICKS_PER_UNIT = 10000000,
   parameter int NUM_SONGS      = 3,
   parameter int MAX_NOTES      = 64,
   parameter int DUR_W          = 4,
   parameter int OCT_W          = 2
`ifdef AUTO_SEQ_GAP_EN
   ,parameter int GAP_TICKS     = 4
`endif
) (
   input  logic                                           clk,
   input  logic                                           reset,
   input  logic                                           btn_next,
   input  logic                                           btn_prev,
   input  logic                                           play_en,
   input  logic                                           loop_en,
   input  logic [1:0]                                     tempo_shift,
   output logic                                           rom_req,
   output logic [$clog2(NUM_SONGS)+$clog2(MAX_NOTES)-1:0] rom_addr,
   input  logic                                           rom_valid,
   input  logic [3:0]                                     rom_note,
   input  logic [DUR_W-1:0]                               rom_dur,
   input  logic [OCT_W-1:0]                               rom_oct,
   output logic [3:0]                                     note_to_play,
   output logic [OCT_W-1:0]                               octave_auto,
   output logic [6:0]                                     led_out,
   output logic [$clog2(NUM_SONGS)-1:0]                   song_num,
   output logic                                           song_done
);

   localparam int          SONG_W    = $clog2(NUM_SONGS);
   localparam int          POS_W     = $clog2(MAX_NOTES);
   localparam logic [63:0] MAX_TICKS = 64'(TICKS_PER_UNIT) * ((64'd1 << DUR_W) - 64'd1);
   localparam int          CNT_W     = (MAX_TICKS > 64'd1) ? $clog2(MAX_TICKS) : 1;
`ifdef AUTO_SEQ_GAP_EN
   localparam int          GAP_W     = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
`endif

   state_e                    state_q, state_d;
   logic [SONG_W-1:0]         song_q, song_d;
   logic [POS_W-1:0]          pos_q, pos_d;
   logic                      wrapped_q, wrapped_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [3:0]                note_q, note_d;
   logic [OCT_W-1:0]          oct_q, oct_d;
   logic [6:0]                led_q, led_d;
   logic                      done_q, done_d;
   logic                      req_q, req_d;
   logic [SONG_W+POS_W-1:0]   addr_q, addr_d;
`ifdef AUTO_SEQ_GAP_EN
   logic [GAP_W-1:0]          gap_q, gap_d;
`endif

   logic                      next_rise_s, prev_rise_s, song_chg_s, last_pos_s;
   logic [63:0]               unit_s, dur_s, ticks_s;
   logic [CNT_W-1:0]          load_cnt_s;

   edge_detect u_next (.clk(clk), .reset(reset), .sig_i(btn_next), .rise_o(next_rise_s));
   edge_detect u_prev (.clk(clk), .reset(reset), .sig_i(btn_prev), .rise_o(prev_rise_s));

   assign song_chg_s = next_rise_s | prev_rise_s;
   assign last_pos_s = (pos_q == POS_W'(MAX_NOTES - 1));

   // note length in ticks; a zero duration plays as one unit
   always_comb begin
      unit_s     = 64'(TICKS_PER_UNIT) >> tempo_shift;
      dur_s      = (rom_dur == '0) ? 64'd1 : 64'(rom_dur);
      ticks_s    = unit_s * dur_s;
      load_cnt_s = (ticks_s == 64'd0) ? '0 : CNT_W'(ticks_s - 64'd1);
   end

   // sequencing FSM: next state and next register values
   always_comb begin
      state_d   = state_q;
      song_d    = song_q;
      pos_d     = pos_q;
      wrapped_d = wrapped_q;
      cnt_d     = cnt_q;
      note_d    = note_q;
      oct_d     = oct_q;
      led_d     = led_q;
      done_d    = done_q;
      req_d     = 1'b0;
      addr_d    = addr_q;
`ifdef AUTO_SEQ_GAP_EN
      gap_d     = gap_q;
`endif
      if (song_chg_s) begin
         if (next_rise_s) begin
            song_d = (song_q == SONG_W'(NUM_SONGS - 1)) ? '0 : song_q + SONG_W'(1);
         end else begin
            song_d = (song_q == '0) ? SONG_W'(NUM_SONGS - 1) : song_q - SONG_W'(1);
         end
         pos_d     = '0;
         wrapped_d = 1'b0;
         note_d    = NOTE_REST;
         led_d     = 7'd0;
         done_d    = 1'b0;
         // a request still in flight must have its response swallowed
         state_d   = ((state_q == ST_WAIT || state_q == ST_FLUSH) && !rom_valid) ? ST_FLUSH : ST_FETCH;
      end else begin
         case (state_q)
            ST_FETCH: begin
               req_d   = 1'b1;
               addr_d  = {song_q, pos_q};
               state_d = ST_WAIT;
            end
            ST_WAIT: begin
               if (!rom_valid) begin
                  state_d = ST_WAIT;
               end else if (rom_note == NOTE_END || wrapped_q) begin
                  if (loop_en) begin
                     pos_d     = '0;
                     wrapped_d = 1'b0;
                     state_d   = ST_FETCH;
                  end else begin
                     note_d  = NOTE_REST;
                     led_d   = 7'd0;
                     done_d  = 1'b1;
                     state_d = ST_DONE;
                  end
               end else begin
                  note_d  = rom_note;
                  oct_d   = rom_oct;
                  led_d   = note_to_led(rom_note);
                  cnt_d   = load_cnt_s;
                  state_d = ST_PLAY;
               end
            end
            ST_PLAY: begin
               if (!play_en) begin
                  cnt_d = cnt_q;
               end else if (cnt_q == '0) begin
                  pos_d     = last_pos_s ? '0 : pos_q + POS_W'(1);
                  wrapped_d = wrapped_q | last_pos_s;
`ifdef AUTO_SEQ_GAP_EN
                  note_d    = NOTE_REST;
                  gap_d     = GAP_W'(GAP_TICKS - 1);
                  state_d   = ST_GAP;
`else
                  state_d   = ST_FETCH;
`endif
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
`ifdef AUTO_SEQ_GAP_EN
            ST_GAP: begin
               if (!play_en) begin
                  gap_d = gap_q;
               end else if (gap_q == '0) begin
                  state_d = ST_FETCH;
               end else begin
                  gap_d = gap_q - GAP_W'(1);
               end
            end
`endif
            ST_FLUSH: begin
               if (rom_valid) begin
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_FLUSH;
               end
            end
            ST_DONE: begin
               if (loop_en) begin
                  pos_d     = '0;
                  wrapped_d = 1'b0;
                  done_d    = 1'b0;
                  state_d   = ST_FETCH;
               end else begin
                  state_d = ST_DONE;
               end
            end
            default: state_d = ST_FETCH;
         endcase
      end
   end

   // state and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_FETCH;
         song_q    <= '0;
         pos_q     <= '0;
         wrapped_q <= 1'b0;
         cnt_q     <= '0;
         note_q    <= NOTE_REST;
         oct_q     <= '0;
         led_q     <= 7'd0;
         done_q    <= 1'b0;
         req_q     <= 1'b0;
         addr_q    <= '0;
`ifdef AUTO_SEQ_GAP_EN
         gap_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         song_q    <= song_d;
         pos_q     <= pos_d;
         wrapped_q <= wrapped_d;
         cnt_q     <= cnt_d;
         note_q    <= note_d;
         oct_q     <= oct_d;
         led_q     <= led_d;
         done_q    <= done_d;
         req_q     <= req_d;
         addr_q    <= addr_d;
`ifdef AUTO_SEQ_GAP_EN
         gap_q     <= gap_d;
`endif
      end
   end

   // pausing silences the buzzer but keeps LED and octave showing the held note
   assign note_to_play = (state_q == ST_PLAY && !play_en) ? NOTE_REST : note_q;
   assign octave_auto  = oct_q;
   assign led_out      = led_q;
   assign song_num     = song_q;
   assign song_done    = done_q;
   assign rom_req      = req_q;
   assign rom_addr     = addr_q;

endmodule
